// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencing for load-use, taken-branch redirect and multi-cycle mul/div in EX.
// Zero latency: outputs are combinational from state and current inputs; holds IF..EX while mul/div is busy.
module pipeline_hazard_controller #(
  parameter int WIDTH         = 5,
  parameter int MD_MAX_CYCLES = 64,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     RegS1D,
  input  logic [WIDTH-1:0]     RegS2D,
  input  logic [WIDTH-1:0]     WriteRegE,
  input  logic                 MemReadE,
  input  logic                 RegWE,
  input  logic                 BranchTakenE,
  input  logic                 MdStartE,
  input  logic                 MdDoneE,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 StallE,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 FlushM,
  output logic                 md_timeout,
  output logic [CNT_WIDTH-1:0] stall_cycles
);

  localparam int MDW = $clog2(MD_MAX_CYCLES + 1);

  typedef enum logic {RUN, MD_BUSY} state_t;

  state_t         state, state_nxt;
  logic [MDW-1:0] md_cnt, md_cnt_nxt;
  logic           timeout_set;
  logic           load_use;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  assign load_use = MemReadE & RegWE & (WriteRegE != '0) &
                    ((WriteRegE == RegS1D) | (WriteRegE == RegS2D));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      md_cnt <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    md_cnt_nxt  = md_cnt;
    timeout_set = 1'b0;
    StallF      = 1'b0;
    StallD      = 1'b0;
    StallE      = 1'b0;
    FlushD      = 1'b0;
    FlushE      = 1'b0;
    FlushM      = 1'b0;
    if (!rst) begin
      case (state)
        RUN: begin
          if (BranchTakenE) begin
            // redirect squashes both the ID instruction and any mul/div issue
            FlushD = 1'b1;
            FlushE = 1'b1;
          end else if (MdStartE && !MdDoneE) begin
            StallF     = 1'b1;
            StallD     = 1'b1;
            StallE     = 1'b1;
            FlushM     = 1'b1;
            state_nxt  = MD_BUSY;
            md_cnt_nxt = MDW'(1);
          end else if (load_use) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
          end
        end
        MD_BUSY: begin
          if (MdDoneE) begin
            state_nxt = RUN;
          end else if (md_cnt >= MDW'(MD_MAX_CYCLES)) begin
            // forced release: behaves like completion but flags the hang
            timeout_set = 1'b1;
            state_nxt   = RUN;
          end else begin
            StallF     = 1'b1;
            StallD     = 1'b1;
            StallE     = 1'b1;
            FlushM     = 1'b1;
            md_cnt_nxt = md_cnt + MDW'(1);
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      md_timeout   <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (timeout_set)
        md_timeout <= 1'b1;
      if (StallF && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_WIDTH'(1);
    end
  end

endmodule
